// File: rtl/riscv_fetch_aligner.sv
// ----------------------------------------------------------------------------
// riscv_fetch_aligner
//
// Fetch-stage aligner for an RV64IMC pipeline. It reads 32-bit words from a
// combinational instruction memory and splits the halfword stream into
// 16-bit compressed and 32-bit instructions. A 32-bit instruction that
// straddles a word boundary is assembled from a buffered upper halfword and
// the lower half of the next word. Results go into the F/D output registers.
//
// Ports:
//   i_riscv_algn_clk        clock, rising edge
//   i_riscv_algn_rst        synchronous active-high reset
//   i_riscv_algn_stall      freeze all state and outputs
//   i_riscv_algn_flush      redirect to i_riscv_algn_target (beats stall)
//   i_riscv_algn_target     redirect PC, bit 0 ignored
//   o_riscv_algn_imem_addr  word-aligned fetch address
//   i_riscv_algn_imem_rdata combinational read data for imem_addr
//   o_riscv_algn_instr      raw instruction (compressed: zero-extended)
//   o_riscv_algn_pc         PC of o_riscv_algn_instr
//   o_riscv_algn_pcplus     pc+2 (compressed) or pc+4
//   o_riscv_algn_cinst      instruction is 16-bit
//   o_riscv_algn_valid      0 = bubble
// ----------------------------------------------------------------------------
module riscv_fetch_aligner #(
    parameter int unsigned       XLEN     = 64,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            i_riscv_algn_clk,
    input  logic            i_riscv_algn_rst,
    input  logic            i_riscv_algn_stall,
    input  logic            i_riscv_algn_flush,
    input  logic [XLEN-1:0] i_riscv_algn_target,
    output logic [XLEN-1:0] o_riscv_algn_imem_addr,
    input  logic [31:0]     i_riscv_algn_imem_rdata,
    output logic [31:0]     o_riscv_algn_instr,
    output logic [XLEN-1:0] o_riscv_algn_pc,
    output logic [XLEN-1:0] o_riscv_algn_pcplus,
    output logic            o_riscv_algn_cinst,
    output logic            o_riscv_algn_valid
);

    typedef enum logic [1:0] {
        ALIGNED = 2'd0,  // next instruction starts at faddr
        UPPER   = 2'd1,  // next instruction starts at faddr+2
        SPLIT   = 2'd2   // hbuf holds low half of instruction at faddr-2
    } state_e;

    localparam logic [31:0]     NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] TWO         = XLEN'(2);
    localparam logic [XLEN-1:0] FOUR        = XLEN'(4);
    localparam logic [XLEN-1:0] RESET_FADDR = {RESET_PC[XLEN-1:2], 2'b00};
    localparam state_e          RESET_STATE = RESET_PC[1] ? UPPER : ALIGNED;

    logic [XLEN-1:0] faddr_q,  faddr_d;
    logic [15:0]     hbuf_q,   hbuf_d;
    state_e          state_q,  state_d;
    logic [31:0]     instr_q,  instr_d;
    logic [XLEN-1:0] pc_q,     pc_d;
    logic [XLEN-1:0] pcplus_q, pcplus_d;
    logic            cinst_q,  cinst_d;
    logic            valid_q,  valid_d;

    logic            emit;
    logic [XLEN-1:0] emit_pc;
    logic [31:0]     emit_instr;
    logic            emit_c;

    logic [31:0]     w;
    logic            unused_target_b0;

    assign w                = i_riscv_algn_imem_rdata;
    assign unused_target_b0 = i_riscv_algn_target[0];

    always_comb begin
        faddr_d    = faddr_q;
        hbuf_d     = hbuf_q;
        state_d    = state_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pcplus_d   = pcplus_q;
        cinst_d    = cinst_q;
        valid_d    = valid_q;
        emit       = 1'b0;
        emit_pc    = faddr_q;
        emit_instr = NOP;
        emit_c     = 1'b0;

        if (i_riscv_algn_flush) begin
            faddr_d = {i_riscv_algn_target[XLEN-1:2], 2'b00};
            state_d = i_riscv_algn_target[1] ? UPPER : ALIGNED;
            hbuf_d  = '0;
            instr_d = NOP;
            cinst_d = 1'b0;
            valid_d = 1'b0;
        end else if (!i_riscv_algn_stall) begin
            // Bubble unless one of the states below emits; pc/pcplus hold.
            instr_d = NOP;
            cinst_d = 1'b0;
            valid_d = 1'b0;

            unique case (state_q)
                ALIGNED: begin
                    emit    = 1'b1;
                    emit_pc = faddr_q;
                    if (w[1:0] != 2'b11) begin
                        emit_instr = {16'h0000, w[15:0]};
                        emit_c     = 1'b1;
                        state_d    = UPPER;
                    end else begin
                        emit_instr = w;
                        faddr_d    = faddr_q + FOUR;
                    end
                end
                UPPER: begin
                    faddr_d = faddr_q + FOUR;
                    if (w[17:16] != 2'b11) begin
                        emit       = 1'b1;
                        emit_pc    = faddr_q + TWO;
                        emit_instr = {16'h0000, w[31:16]};
                        emit_c     = 1'b1;
                        state_d    = ALIGNED;
                    end else begin
                        // Straddling 32-bit instruction: park the low half
                        // and fetch the next word, costing one bubble.
                        hbuf_d  = w[31:16];
                        state_d = SPLIT;
                    end
                end
                SPLIT: begin
                    emit       = 1'b1;
                    emit_pc    = faddr_q - TWO;
                    emit_instr = {w[15:0], hbuf_q};
                    state_d    = UPPER;
                end
                default: state_d = ALIGNED;
            endcase

            if (emit) begin
                valid_d  = 1'b1;
                instr_d  = emit_instr;
                cinst_d  = emit_c;
                pc_d     = emit_pc;
                pcplus_d = emit_pc + (emit_c ? TWO : FOUR);
            end
        end
    end

    always_ff @(posedge i_riscv_algn_clk) begin
        if (i_riscv_algn_rst) begin
            faddr_q  <= RESET_FADDR;
            hbuf_q   <= '0;
            state_q  <= RESET_STATE;
            instr_q  <= NOP;
            pc_q     <= '0;
            pcplus_q <= '0;
            cinst_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            faddr_q  <= faddr_d;
            hbuf_q   <= hbuf_d;
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            pcplus_q <= pcplus_d;
            cinst_q  <= cinst_d;
            valid_q  <= valid_d;
        end
    end

    assign o_riscv_algn_imem_addr = faddr_q;
    assign o_riscv_algn_instr     = instr_q;
    assign o_riscv_algn_pc        = pc_q;
    assign o_riscv_algn_pcplus    = pcplus_q;
    assign o_riscv_algn_cinst     = cinst_q;
    assign o_riscv_algn_valid     = valid_q;

endmodule

// File: tb/tb_riscv_fetch_aligner.sv
module tb_riscv_fetch_aligner;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [63:0] target;
        logic [63:0] addr;
        logic        valid;
        logic [63:0] pc;
        logic [63:0] pcplus;
        logic [31:0] instr;
        logic        cinst;
    } vec_t;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk;
    int          checks;
    int          failures;

    // DUT 1: RESET_PC = 0
    logic        rst, stall, flush;
    logic [63:0] target, addr, pc, pcplus;
    logic [31:0] rdata, instr;
    logic        cinst, valid;
    logic [31:0] mem [0:127];

    // DUT 2: RESET_PC at top of address space
    logic        rst2, stall2, flush2;
    logic [63:0] target2, addr2, pc2, pcplus2;
    logic [31:0] rdata2, instr2;
    logic        cinst2, valid2;

    vec_t tbl[$];
    vec_t sb_q[$];

    assign rdata  = mem[addr[8:2]];
    assign rdata2 = (addr2 == WRAP_PC) ? 32'h0050_0093 :
                    (addr2 == 64'h0)   ? 32'h0005_0001 : 32'h0;

    riscv_fetch_aligner #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .i_riscv_algn_clk        (clk),
        .i_riscv_algn_rst        (rst),
        .i_riscv_algn_stall      (stall),
        .i_riscv_algn_flush      (flush),
        .i_riscv_algn_target     (target),
        .o_riscv_algn_imem_addr  (addr),
        .i_riscv_algn_imem_rdata (rdata),
        .o_riscv_algn_instr      (instr),
        .o_riscv_algn_pc         (pc),
        .o_riscv_algn_pcplus     (pcplus),
        .o_riscv_algn_cinst      (cinst),
        .o_riscv_algn_valid      (valid)
    );

    riscv_fetch_aligner #(.XLEN(64), .RESET_PC(WRAP_PC)) dut2 (
        .i_riscv_algn_clk        (clk),
        .i_riscv_algn_rst        (rst2),
        .i_riscv_algn_stall      (stall2),
        .i_riscv_algn_flush      (flush2),
        .i_riscv_algn_target     (target2),
        .o_riscv_algn_imem_addr  (addr2),
        .i_riscv_algn_imem_rdata (rdata2),
        .o_riscv_algn_instr      (instr2),
        .o_riscv_algn_pc         (pc2),
        .o_riscv_algn_pcplus     (pcplus2),
        .o_riscv_algn_cinst      (cinst2),
        .o_riscv_algn_valid      (valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic f, input logic [63:0] t,
                       input logic [63:0] a, input logic v, input logic [63:0] p,
                       input logic [63:0] pp, input logic [31:0] i, input logic c);
        vec_t e;
        e.rst = r; e.stall = s; e.flush = f; e.target = t;
        e.addr = a; e.valid = v; e.pc = p; e.pcplus = pp; e.instr = i; e.cinst = c;
        tbl.push_back(e);
    endtask

    task automatic check_out(input string tag, input int idx, input vec_t e,
                             input logic [63:0] a, input logic v, input logic [63:0] p,
                             input logic [63:0] pp, input logic [31:0] i, input logic c);
        cmp({tag, ".addr"},   idx, a,  e.addr);
        cmp({tag, ".valid"},  idx, {63'h0, v}, {63'h0, e.valid});
        cmp({tag, ".instr"},  idx, {32'h0, i}, {32'h0, e.instr});
        cmp({tag, ".cinst"},  idx, {63'h0, c}, {63'h0, e.cinst});
        // pc/pcplus are checked always: bubbles must hold the previous values
        cmp({tag, ".pc"},     idx, p,  e.pc);
        cmp({tag, ".pcplus"}, idx, pp, e.pcplus);
    endtask

    initial begin
        vec_t e;
        checks   = 0;
        failures = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; target = '0;
        rst2 = 1'b1; stall2 = 1'b0; flush2 = 1'b0; target2 = '0;

        for (int k = 0; k < 128; k++) mem[k] = 32'h0;
        mem[0]  = 32'h0050_0093;  // 0x00: addi
        mem[1]  = 32'h0005_0001;  // 0x04: C 0001, 0x06: C 0005
        mem[2]  = 32'h00A0_0113;  // 0x08: 32-bit
        mem[3]  = 32'h0093_0001;  // 0x0C: C 0001, 0x0E: low half of straddle
        mem[4]  = 32'h0001_0050;  // 0x10: high half, 0x12: C 0001
        mem[5]  = 32'h0030_0193;  // 0x14
        mem[6]  = 32'h0040_0213;  // 0x18
        mem[7]  = 32'h0113_4501;  // 0x1C: C 4501, 0x1E: straddle start
        mem[64] = 32'h8082_0000;  // 0x100 / 0x102: C 8082
        mem[65] = 32'h0010_0513;  // 0x104
        mem[67] = 32'h0293_FFFF;  // 0x10E: straddle start
        mem[68] = 32'h0001_0070;  // 0x110 high half, 0x112: C 0001
        mem[69] = 32'h0393_0001;  // 0x114: C 0001, 0x116: straddle start

        //   rst stl fl target     addr     v  pc       pcplus   instr          c
        add(1, 0, 0, 64'h0,   64'h0,   0, 64'h0,   64'h0,   32'h0000_0013, 0); // 0 reset
        add(0, 0, 0, 64'h0,   64'h4,   1, 64'h0,   64'h4,   32'h0050_0093, 0); // 1
        add(0, 0, 0, 64'h0,   64'h4,   1, 64'h4,   64'h6,   32'h0000_0001, 1); // 2
        add(0, 0, 0, 64'h0,   64'h8,   1, 64'h6,   64'h8,   32'h0000_0005, 1); // 3
        add(0, 0, 0, 64'h0,   64'hC,   1, 64'h8,   64'hC,   32'h00A0_0113, 0); // 4
        add(0, 0, 0, 64'h0,   64'hC,   1, 64'hC,   64'hE,   32'h0000_0001, 1); // 5
        add(0, 0, 0, 64'h0,   64'h10,  0, 64'hC,   64'hE,   32'h0000_0013, 0); // 6 bubble
        add(0, 0, 0, 64'h0,   64'h10,  1, 64'hE,   64'h12,  32'h0050_0093, 0); // 7 straddle
        add(0, 0, 0, 64'h0,   64'h14,  1, 64'h12,  64'h14,  32'h0000_0001, 1); // 8
        add(0, 0, 0, 64'h0,   64'h18,  1, 64'h14,  64'h18,  32'h0030_0193, 0); // 9
        add(0, 1, 0, 64'h0,   64'h18,  1, 64'h14,  64'h18,  32'h0030_0193, 0); // 10 stall
        add(0, 1, 0, 64'h0,   64'h18,  1, 64'h14,  64'h18,  32'h0030_0193, 0); // 11 stall
        add(0, 1, 0, 64'h0,   64'h18,  1, 64'h14,  64'h18,  32'h0030_0193, 0); // 12 stall
        add(0, 0, 0, 64'h0,   64'h1C,  1, 64'h18,  64'h1C,  32'h0040_0213, 0); // 13
        add(0, 0, 0, 64'h0,   64'h1C,  1, 64'h1C,  64'h1E,  32'h0000_4501, 1); // 14
        add(0, 0, 0, 64'h0,   64'h20,  0, 64'h1C,  64'h1E,  32'h0000_0013, 0); // 15 -> SPLIT
        add(0, 1, 1, 64'h102, 64'h100, 0, 64'h1C,  64'h1E,  32'h0000_0013, 0); // 16 flush+stall
        add(0, 0, 0, 64'h0,   64'h104, 1, 64'h102, 64'h104, 32'h0000_8082, 1); // 17
        add(0, 0, 0, 64'h0,   64'h108, 1, 64'h104, 64'h108, 32'h0010_0513, 0); // 18
        add(0, 0, 1, 64'h10F, 64'h10C, 0, 64'h104, 64'h108, 32'h0000_0013, 0); // 19 flush
        add(0, 0, 0, 64'h0,   64'h110, 0, 64'h104, 64'h108, 32'h0000_0013, 0); // 20 bubble
        add(0, 0, 0, 64'h0,   64'h110, 1, 64'h10E, 64'h112, 32'h0070_0293, 0); // 21
        add(0, 0, 0, 64'h0,   64'h114, 1, 64'h112, 64'h114, 32'h0000_0001, 1); // 22
        add(0, 0, 0, 64'h0,   64'h114, 1, 64'h114, 64'h116, 32'h0000_0001, 1); // 23
        add(0, 0, 0, 64'h0,   64'h118, 0, 64'h114, 64'h116, 32'h0000_0013, 0); // 24 -> SPLIT
        add(1, 1, 1, 64'h100, 64'h0,   0, 64'h0,   64'h0,   32'h0000_0013, 0); // 25 reset wins
        add(0, 0, 0, 64'h0,   64'h4,   1, 64'h0,   64'h4,   32'h0050_0093, 0); // 26

        for (int n = 0; n < tbl.size(); n++) begin
            rst    = tbl[n].rst;
            stall  = tbl[n].stall;
            flush  = tbl[n].flush;
            target = tbl[n].target;
            sb_q.push_back(tbl[n]);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check_out("main", n, e, addr, valid, pc, pcplus, instr, cinst);
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        // Wrap-around sequence on the second instance.
        e = tbl[0];
        e.addr = WRAP_PC; e.valid = 0; e.pc = 64'h0; e.pcplus = 64'h0;
        e.instr = 32'h0000_0013; e.cinst = 0;
        rst2 = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        check_out("wrap", 0, e, addr2, valid2, pc2, pcplus2, instr2, cinst2);

        rst2 = 1'b0;
        e.addr = 64'h0; e.valid = 1; e.pc = WRAP_PC; e.pcplus = 64'h0;
        e.instr = 32'h0050_0093; e.cinst = 0;
        sb_q.push_back(e);
        e.addr = 64'h0; e.valid = 1; e.pc = 64'h0; e.pcplus = 64'h2;
        e.instr = 32'h0000_0001; e.cinst = 1;
        sb_q.push_back(e);
        for (int n = 1; n <= 2; n++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL wrap.scoreboard step %0d: got empty queue expected entry", n);
            end else begin
                e = sb_q.pop_front();
                check_out("wrap", n, e, addr2, valid2, pc2, pcplus2, instr2, cinst2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
